// File: rtl/hazard_scoreboard.sv
// Registered E/M/W hazard scoreboard: D-stage stall and operand forward selects.
// Define HAZARD_MDU_EN to build the mult/div busy counter, its stall and md_busy.
module hazard_scoreboard #(
    parameter int AW          = 5,
    parameter int TW          = 3,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [AW-1:0] d_rs,
    input  logic [AW-1:0] d_rt,
    input  logic [TW-1:0] d_tuse_rs,
    input  logic [TW-1:0] d_tuse_rt,
    input  logic [AW-1:0] d_a3,
    input  logic          d_regwrite,
    input  logic [TW-1:0] d_tnew,
    input  logic          d_ld,
    input  logic          d_md_use,
    input  logic          d_md_start,
    input  logic          d_md_div,
    output logic          stall,
    output logic [1:0]    fwd_d_rs,
    output logic [1:0]    fwd_d_rt,
    output logic [1:0]    fwd_e_rs,
    output logic [1:0]    fwd_e_rt,
    output logic [1:0]    fwd_m_rt,
    output logic          md_busy
);

    typedef struct packed {
        logic [AW-1:0] rs;
        logic [AW-1:0] rt;
        logic [AW-1:0] a3;
        logic          wnz;
        logic [TW-1:0] tnew;
        logic          ld;
`ifdef HAZARD_MDU_EN
        logic          md_start;
        logic          md_div;
`endif
    } entry_t;

    entry_t e_q, m_q, w_q;
    entry_t e_d, m_d, w_d;
    logic   rs_stall_s, rt_stall_s, md_stall_s;

    function automatic logic [TW-1:0] dec_sat(input logic [TW-1:0] v);
        logic [TW-1:0] r;
        if (v == '0) r = '0;
        else         r = v - TW'(1);
        return r;
    endfunction

    function automatic logic raw_hit(input logic [AW-1:0] r, input logic [TW-1:0] tuse,
                                     input entry_t x);
        return x.wnz && (x.a3 == r) && (tuse < x.tnew);
    endfunction

    function automatic logic [1:0] w_fwd(input logic [AW-1:0] r, input entry_t w);
        logic [1:0] sel;
        if (w.wnz && (w.a3 == r) && (w.tnew == '0)) sel = w.ld ? 2'd3 : 2'd2;
        else                                         sel = 2'd0;
        return sel;
    endfunction

    // M (ALU only) wins over W for the same register.
    function automatic logic [1:0] mw_fwd(input logic [AW-1:0] r, input entry_t m, input entry_t w);
        logic [1:0] sel;
        if (m.wnz && (m.a3 == r) && (m.tnew == '0) && !m.ld) sel = 2'd1;
        else                                                  sel = w_fwd(r, w);
        return sel;
    endfunction

    assign rs_stall_s = raw_hit(d_rs, d_tuse_rs, e_q) | raw_hit(d_rs, d_tuse_rs, m_q)
                      | raw_hit(d_rs, d_tuse_rs, w_q);
    assign rt_stall_s = raw_hit(d_rt, d_tuse_rt, e_q) | raw_hit(d_rt, d_tuse_rt, m_q)
                      | raw_hit(d_rt, d_tuse_rt, w_q);
    assign stall      = rs_stall_s | rt_stall_s | md_stall_s;

    assign fwd_d_rs = mw_fwd(d_rs, m_q, w_q);
    assign fwd_d_rt = mw_fwd(d_rt, m_q, w_q);
    assign fwd_e_rs = mw_fwd(e_q.rs, m_q, w_q);
    assign fwd_e_rt = mw_fwd(e_q.rt, m_q, w_q);
    assign fwd_m_rt = w_fwd(m_q.rt, w_q);

    // Next E record: the D instruction, or a bubble while D is held.
    always_comb begin
        e_d = '0;
        if (!stall) begin
            e_d.rs   = d_rs;
            e_d.rt   = d_rt;
            e_d.a3   = d_a3;
            e_d.wnz  = d_regwrite && (d_a3 != '0);
            e_d.tnew = dec_sat(d_tnew);
            e_d.ld   = d_ld;
`ifdef HAZARD_MDU_EN
            e_d.md_start = d_md_start;
            e_d.md_div   = d_md_div;
`endif
        end else begin
            e_d = '0;
        end
    end

    // Downstream shift with Tnew counting towards zero.
    always_comb begin
        m_d      = e_q;
        m_d.tnew = dec_sat(e_q.tnew);
        w_d      = m_q;
        w_d.tnew = dec_sat(m_q.tnew);
    end

    // Scoreboard entry registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            e_q <= '0;
            m_q <= '0;
            w_q <= '0;
        end else begin
            e_q <= e_d;
            m_q <= m_d;
            w_q <= w_d;
        end
    end

`ifdef HAZARD_MDU_EN
    localparam int MAX_CYCLES = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    logic [CW-1:0] md_cnt_q, md_cnt_d;
    logic          unused_s;

    // Busy count starts when a mult/div leaves E.
    always_comb begin
        md_cnt_d = md_cnt_q;
        if (e_q.md_start) begin
            md_cnt_d = e_q.md_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
        end else if (md_cnt_q != '0) begin
            md_cnt_d = md_cnt_q - CW'(1);
        end else begin
            md_cnt_d = md_cnt_q;
        end
    end

    // MDU busy counter register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) md_cnt_q <= '0;
        else          md_cnt_q <= md_cnt_d;
    end

    assign md_busy    = (md_cnt_q != '0);
    assign md_stall_s = d_md_use && (md_busy || e_q.md_start);
    assign unused_s   = ^w_q;
`else
    logic unused_s;

    assign md_busy    = 1'b0;
    assign md_stall_s = 1'b0;
    assign unused_s   = ^{w_q, d_md_use, d_md_start, d_md_div};
`endif

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Registered hazard unit for the 5-stage pipeline (F/D/E/M/W). It captures each instruction's hazard record at issue from D and shifts it down an internal E/M/W scoreboard, counting Tnew down each cycle. Operand forwarding selects and the D-stage stall come from the scoreboard plus the current D instruction. A multi-cycle mult/div busy counter blocks HI/LO-dependent instructions.

## Interface
Parameters:
- `AW`, 5, register address width
- `TW`, 3, Tnew/Tuse counter width
- `MULT_CYCLES`, 5, busy cycles after a mult leaves E
- `DIV_CYCLES`, 10, busy cycles after a div leaves E

Ports:
- `clk` in 1: clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `d_rs`, `d_rt` in AW: D-stage source registers.
- `d_tuse_rs`, `d_tuse_rt` in TW: D-stage Tuse. All-ones means unused.
- `d_a3` in AW: D-stage destination register.
- `d_regwrite` in 1: the D instruction writes the GRF.
- `d_tnew` in TW: D-stage Tnew. calr/cali/jal = 2, lw = 3, others = 0.
- `d_ld` in 1: the result comes from DM.
- `d_md_use` in 1: the D instruction uses the MDU (mult/div/mfhi/mflo/mthi/mtlo).
- `d_md_start` in 1: the D instruction is mult or div.
- `d_md_div` in 1: qualifies `d_md_start` as div.
- `stall` out 1: freeze PC and F/D; inject a bubble into E.
- `fwd_d_rs`, `fwd_d_rt`, `fwd_e_rs`, `fwd_e_rt`, `fwd_m_rt` out 2: forward selects.
  - 0 = register file / pipe value
  - 1 = EM ALU result
  - 2 = MW ALU result
  - 3 = MW DM data
- `md_busy` out 1: MDU counter nonzero.

## Operation
- Entries E, M, W each hold: rs, rt, a3, wnz, tnew, ld, md_start, md_div.
  - wnz = regwrite && a3 != 0.
- Shift on every clock edge:
  - W ← M, M ← E.
  - tnew is decremented, saturating at 0.
- E load:
  - When `stall` = 0: E ← D inputs, with tnew = d_tnew − 1 (saturating).
  - When `stall` = 1: E ← bubble, all fields 0.
- Stall for rs: any entry X in {E, M, W} with X.wnz, X.a3 == d_rs, and d_tuse_rs < X.tnew. The rt case is identical using d_rt / d_tuse_rt. `stall` = rs-stall | rt-stall | MDU-stall.
- MDU stall: d_md_use && (md_busy || E.md_start).
- Forward to D operand r (rs or rt), in priority order:
  - M.wnz && M.a3 == r && M.tnew == 0 && !M.ld → 1.
  - Otherwise W.wnz && W.a3 == r && W.tnew == 0 → 3 if W.ld, else 2.
  - Otherwise 0.
- `fwd_e_rs` / `fwd_e_rt`: same rule, using E.rs / E.rt.
- `fwd_m_rt`: W rule only, using M.rt.
- MDU counter:
  - At an edge where E.md_start = 1: load DIV_CYCLES if E.md_div, else MULT_CYCLES.
  - Otherwise decrement if nonzero.
  - `md_busy` = counter != 0.
  - A new start while busy reloads the counter; it cannot arise, since md_use stalls in D.
- Counter width: clog2(max(MULT_CYCLES, DIV_CYCLES) + 1).

## Timing
- Reset, asynchronous on `reset_n` low: all entries 0, counter 0.
  - Outputs during and after reset: `stall` = 0 (given D Tuse alone cannot stall), all fwd = 0, `md_busy` = 0.
- Outputs:
  - `stall` and `fwd_d_*` are combinational from D inputs and registered entries; they are valid in the same cycle.
  - `fwd_e_*`, `fwd_m_rt` and `md_busy` depend on registers only.
- Latency: a record issued at edge n is visible in E during cycle n+1, M during n+2, W during n+3.
- Reset mid-operation clears in-flight records and the MDU count. Pipeline registers are reset by their own owners.

## Configuration
- `HAZARD_MDU_EN` defined: MDU counter, MDU stall and `md_busy` are present.
- Not defined:
  - `d_md_use`, `d_md_start` and `d_md_div` are ignored.
  - The counter and md entry fields are not built.
  - `md_busy` is tied to 0; `stall` covers GRF hazards only.

## Test plan
- lw $1 issued, then addu $3,$1,$2 in D:
  - `stall` = 1 for exactly 1 cycle.
  - Next cycle `fwd_d_rs` = 0.
  - Following cycle, addu in E with lw in W: `fwd_e_rs` = 3.
- addu $5 then beq $5,$0: `stall` = 1 for 1 cycle, then `fwd_d_rs` = 1 (M ALU).
- ori $0 then addu $3,$0,$0: `stall` = 0 and all fwd = 0 throughout.
- addu $4 followed directly by ori $4, then sw $4 in D two cycles later: `fwd_d_rt` = 1 (M priority over W).
- div (DIV_CYCLES = 10) then mflo:
  - `md_busy` high for 10 cycles starting the cycle after div leaves E.
  - mflo `stall` = 1 from its D entry until the first cycle `md_busy` = 0.
  - With the macro undefined: no MDU stall.
- Reset asserted mid-div with the counter at 6: `md_busy`, `stall` and all fwd go to 0 immediately (asynchronously), and stay 0 after release with a nop in D.
